// File: rtl/dllp_rx_decoder_mvc.sv
// dllp_rx_decoder_mvc: PCIe DLLP receive decoder.
// Assembles DLLPs, checks CRC-16, decodes Ack/Nak and FC credits.
module dllp_rx_decoder_mvc #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 4,
  parameter int NUM_VC        = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               link_status_i,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep_i,
  input  logic                     s_axis_tvalid_i,
  input  logic                     s_axis_tlast_i,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser_i,
  output logic                     s_axis_tready_o,
  output logic [11:0]              seq_num_o,
  output logic                     seq_num_vld_o,
  output logic                     seq_num_acknack_o,
  output logic [NUM_VC-1:0]        fc1_values_stored_o,
  output logic [NUM_VC-1:0]        fc2_values_stored_o,
  output logic [8*NUM_VC-1:0]      tx_fc_ph_o,
  output logic [12*NUM_VC-1:0]     tx_fc_pd_o,
  output logic [8*NUM_VC-1:0]      tx_fc_nph_o,
  output logic [12*NUM_VC-1:0]     tx_fc_npd_o,
  output logic [8*NUM_VC-1:0]      tx_fc_cplh_o,
  output logic [12*NUM_VC-1:0]     tx_fc_cpld_o,
  output logic                     fc_update_vld_o,
  output logic [ERR_CNT_WIDTH-1:0] crc_err_cnt_o,
  output logic [ERR_CNT_WIDTH-1:0] fmt_err_cnt_o
);

  typedef enum logic {A_IDLE, A_HALF} asm_e;
  typedef enum logic [2:0] {
    K_NONE, K_CRC, K_FMT, K_ACK, K_NAK, K_FC1, K_FC2, K_UPD
  } kind_e;

  typedef logic [ERR_CNT_WIDTH-1:0] cnt_t;

  logic [63:0] din;
  logic [7:0]  kin;
  logic        acc, usr_err;

  logic        rdy_q;
  asm_e        asm_q, asm_d;
  logic [31:0] hold_q, hold_d;
  logic        perr_q, perr_d, kerr_q, kerr_d;
  logic        s1_vld_q, s1_vld_d, s1_fmt_q, s1_fmt_d;
  logic [47:0] s1_data_q, s1_data_d;

  kind_e       s2_kind_q, s2_kind_d;
  logic [2:0]  s2_vc_q;
  logic [1:0]  s2_ft_q;
  logic [7:0]  s2_hdr_q;
  logic [11:0] s2_dat_q;
  logic [7:0]  b0;
  logic [3:0]  hi;
  logic        vc_ok;

  logic [11:0] seq_q, seq_d;
  logic        seq_vld_q, seq_vld_d, an_q, an_d, upd_q, upd_d;
  cnt_t        crc_q, crc_d, fmt_q, fmt_d;
  logic        wr, set1, set2;
  logic [NUM_VC-1:0]        fc2_q, fc2_d;
  logic [NUM_VC-1:0][2:0]   seen_q, seen_d;
  logic [NUM_VC-1:0][7:0]   ph_q, ph_d, nph_q, nph_d, cplh_q, cplh_d;
  logic [NUM_VC-1:0][11:0]  pd_q, pd_d, npd_q, npd_d, cpld_q, cpld_d;

  logic unused_bits;

  assign din     = 64'(s_axis_tdata_i);
  assign kin     = 8'(s_axis_tkeep_i);
  assign acc     = s_axis_tvalid_i & rdy_q;
  assign usr_err = s_axis_tuser_i[0];
  assign unused_bits = ^{din, s_axis_tuser_i, s1_data_q};

  function automatic logic [15:0] dllp_crc(input logic [31:0] d);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
    return r;
  endfunction

  // Assembler: gather beats into one 6-byte DLLP or flag framing errors
  always_comb begin
    asm_d     = asm_q;
    hold_d    = hold_q;
    perr_d    = perr_q;
    kerr_d    = kerr_q;
    s1_vld_d  = 1'b0;
    s1_fmt_d  = 1'b0;
    s1_data_d = s1_data_q;
    if (acc) begin
      if (DATA_WIDTH == 64) begin
        if (!usr_err) begin
          if (s_axis_tlast_i && kin == 8'h3F) begin
            s1_vld_d  = 1'b1;
            s1_data_d = din[47:0];
          end else begin
            s1_fmt_d = 1'b1;
          end
        end
      end else if (asm_q == A_IDLE) begin
        if (s_axis_tlast_i) begin
          s1_fmt_d = !usr_err;
        end else begin
          asm_d  = A_HALF;
          hold_d = din[31:0];
          perr_d = usr_err;
          kerr_d = (kin != 8'h0F);
        end
      end else begin
        asm_d = A_IDLE;
        if (!(perr_q || usr_err)) begin
          if (s_axis_tlast_i && !kerr_q && kin == 8'h03) begin
            s1_vld_d  = 1'b1;
            s1_data_d = {din[15:0], hold_q};
          end else begin
            s1_fmt_d = 1'b1;
          end
        end
      end
    end
  end

  assign b0    = s1_data_q[7:0];
  assign hi    = b0[7:4];
  assign vc_ok = int'(b0[2:0]) < NUM_VC;

  // CRC check and DLLP type classification
  always_comb begin
    s2_kind_d = K_NONE;
    if (s1_fmt_q) begin
      s2_kind_d = K_FMT;
    end else if (s1_vld_q) begin
      if (dllp_crc(s1_data_q[31:0]) !=
          {s1_data_q[39:32], s1_data_q[47:40]}) begin
        s2_kind_d = K_CRC;
      end else begin
        unique case (1'b1)
          (b0 == 8'h00):             s2_kind_d = K_ACK;
          (b0 == 8'h10):             s2_kind_d = K_NAK;
          (hi inside {4'h4, 4'h5, 4'h6}):
            s2_kind_d = vc_ok ? K_FC1 : K_FMT;
          (hi inside {4'hC, 4'hD, 4'hE}):
            s2_kind_d = vc_ok ? K_FC2 : K_FMT;
          (hi inside {4'h8, 4'h9, 4'hA}):
            s2_kind_d = vc_ok ? K_UPD : K_FMT;
          default:                   s2_kind_d = K_FMT;
        endcase
      end
    end
  end

  // Front-end and decode pipeline registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdy_q     <= 1'b0;
      asm_q     <= A_IDLE;
      hold_q    <= '0;
      perr_q    <= 1'b0;
      kerr_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_fmt_q  <= 1'b0;
      s1_data_q <= '0;
      s2_kind_q <= K_NONE;
      s2_vc_q   <= '0;
      s2_ft_q   <= '0;
      s2_hdr_q  <= '0;
      s2_dat_q  <= '0;
    end else begin
      rdy_q     <= 1'b1;
      asm_q     <= asm_d;
      hold_q    <= hold_d;
      perr_q    <= perr_d;
      kerr_q    <= kerr_d;
      s1_vld_q  <= s1_vld_d;
      s1_fmt_q  <= s1_fmt_d;
      s1_data_q <= s1_data_d;
      s2_kind_q <= s2_kind_d;
      s2_vc_q   <= b0[2:0];
      s2_ft_q   <= hi[1:0];
      s2_hdr_q  <= {s1_data_q[13:8], s1_data_q[23:22]};
      s2_dat_q  <= {s1_data_q[19:16], s1_data_q[31:24]};
    end
  end

  // Commit decoded DLLP under link-state gating
  always_comb begin
    seq_d     = seq_q;
    seq_vld_d = 1'b0;
    an_d      = an_q;
    crc_d     = crc_q;
    fmt_d     = fmt_q;
    fc2_d     = fc2_q;
    seen_d    = seen_q;
    ph_d      = ph_q;
    pd_d      = pd_q;
    nph_d     = nph_q;
    npd_d     = npd_q;
    cplh_d    = cplh_q;
    cpld_d    = cpld_q;
    wr        = 1'b0;
    set1      = 1'b0;
    set2      = 1'b0;
    if (link_status_i != 2'b00) begin
      unique case (s2_kind_q)
        K_CRC: crc_d = (&crc_q) ? crc_q : crc_q + cnt_t'(1);
        K_FMT: fmt_d = (&fmt_q) ? fmt_q : fmt_q + cnt_t'(1);
        K_ACK, K_NAK: begin
          if (link_status_i == 2'b11) begin
            seq_d     = s2_dat_q;
            seq_vld_d = 1'b1;
            an_d      = (s2_kind_q == K_ACK);
          end
        end
        K_FC1: begin
          wr   = (link_status_i == 2'b01);
          set1 = wr;
        end
        K_FC2: set2 = (link_status_i == 2'b10);
        K_UPD: begin
          set2 = link_status_i[1];
          wr   = (link_status_i == 2'b11);
        end
        default: ;
      endcase
    end
    upd_d = wr;
    for (int v = 0; v < NUM_VC; v++) begin
      if (link_status_i == 2'b00) begin
        fc2_d[v]  = 1'b0;
        seen_d[v] = '0;
        ph_d[v]   = '0;
        pd_d[v]   = '0;
        nph_d[v]  = '0;
        npd_d[v]  = '0;
        cplh_d[v] = '0;
        cpld_d[v] = '0;
      end else if (3'(v) == s2_vc_q) begin
        if (wr) begin
          unique case (s2_ft_q)
            2'd0: begin
              ph_d[v] = s2_hdr_q;
              pd_d[v] = s2_dat_q;
            end
            2'd1: begin
              nph_d[v] = s2_hdr_q;
              npd_d[v] = s2_dat_q;
            end
            default: begin
              cplh_d[v] = s2_hdr_q;
              cpld_d[v] = s2_dat_q;
            end
          endcase
        end
        if (set1) seen_d[v][s2_ft_q] = 1'b1;
        if (set2) fc2_d[v] = 1'b1;
      end
    end
  end

  // Architectural state and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      seq_q     <= '0;
      seq_vld_q <= 1'b0;
      an_q      <= 1'b0;
      upd_q     <= 1'b0;
      crc_q     <= '0;
      fmt_q     <= '0;
      fc2_q     <= '0;
      seen_q    <= '0;
      ph_q      <= '0;
      pd_q      <= '0;
      nph_q     <= '0;
      npd_q     <= '0;
      cplh_q    <= '0;
      cpld_q    <= '0;
    end else begin
      seq_q     <= seq_d;
      seq_vld_q <= seq_vld_d;
      an_q      <= an_d;
      upd_q     <= upd_d;
      crc_q     <= crc_d;
      fmt_q     <= fmt_d;
      fc2_q     <= fc2_d;
      seen_q    <= seen_d;
      ph_q      <= ph_d;
      pd_q      <= pd_d;
      nph_q     <= nph_d;
      npd_q     <= npd_d;
      cplh_q    <= cplh_d;
      cpld_q    <= cpld_d;
    end
  end

  // InitFC1 complete once P, NP and Cpl were all seen
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) fc1_values_stored_o[v] = &seen_q[v];
  end

  assign s_axis_tready_o     = rdy_q;
  assign seq_num_o           = seq_q;
  assign seq_num_vld_o       = seq_vld_q;
  assign seq_num_acknack_o   = an_q;
  assign fc2_values_stored_o = fc2_q;
  assign tx_fc_ph_o          = ph_q;
  assign tx_fc_pd_o          = pd_q;
  assign tx_fc_nph_o         = nph_q;
  assign tx_fc_npd_o         = npd_q;
  assign tx_fc_cplh_o        = cplh_q;
  assign tx_fc_cpld_o        = cpld_q;
  assign fc_update_vld_o     = upd_q;
  assign crc_err_cnt_o       = crc_q;
  assign fmt_err_cnt_o       = fmt_q;

endmodule
